step_motor_cmd_seq: RTL and testbench

// Command sequencer placed directly upstream of single_step_motor. Buffers motion

---
 rtl/step_motor_cmd_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_step_motor_cmd_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_motor_cmd_seq.sv
`timescale 1ns/1ps
// Command sequencer for single_step_motor: buffers motion commands in a small FIFO and
// runs one start/ack/done handshake per command, with abort-and-flush support.
module step_motor_cmd_seq #(
    parameter int C_STEP_NUMBER_WIDTH = 16,
    parameter int C_SPEED_DATA_WIDTH  = 16,
    parameter int C_MICROSTEP_WIDTH   = 3,
    parameter int C_FIFO_AW           = 3,
    parameter int C_PULSE_CYCLES      = 4,
    parameter int C_ACK_TIMEOUT       = 1024
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [C_SPEED_DATA_WIDTH-1:0]  s_speed,
    input  logic [C_STEP_NUMBER_WIDTH-1:0] s_step,
    input  logic                           s_dir,
    input  logic [C_MICROSTEP_WIDTH-1:0]   s_ms,
    input  logic                           abort,
    output logic [C_SPEED_DATA_WIDTH-1:0]  m_speed,
    output logic [C_STEP_NUMBER_WIDTH-1:0] m_step,
    output logic                           m_dir,
    output logic [C_MICROSTEP_WIDTH-1:0]   m_ms,
    output logic                           m_start,
    output logic                           m_stop,
    input  logic                           m_state,
    output logic                           busy,
    output logic [C_FIFO_AW:0]             fifo_count,
    output logic                           done,
    output logic                           err,
    output logic [2:0]                     dbg_state
);
    localparam int DEPTH = 1 << C_FIFO_AW;
    localparam int CMD_W = C_SPEED_DATA_WIDTH + C_STEP_NUMBER_WIDTH + 1 + C_MICROSTEP_WIDTH;
    localparam int CNT_W = $clog2(C_ACK_TIMEOUT + C_PULSE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_START, ST_WAIT_ACK, ST_WAIT_DONE, ST_STOP, ST_WAIT_IDLE
    } state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [C_FIFO_AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                           full_q, full_d;
    logic                           abort_q;
    logic                           abort_pending_q, abort_pending_d;
    logic [C_SPEED_DATA_WIDTH-1:0]  m_speed_q, m_speed_d;
    logic [C_STEP_NUMBER_WIDTH-1:0] m_step_q, m_step_d;
    logic                           m_dir_q, m_dir_d;
    logic [C_MICROSTEP_WIDTH-1:0]   m_ms_q, m_ms_d;
    logic                           m_start_q, m_start_d, m_stop_q, m_stop_d;
    logic                           done_q, done_d, err_q, err_d;
    logic [CMD_W-1:0]               mem_q [DEPTH];

    logic                           empty, push, pop, abort_rise;
    logic [C_FIFO_AW-1:0]           wr_inc, rd_inc, ptr_diff;
    logic [C_SPEED_DATA_WIDTH-1:0]  head_speed;
    logic [C_STEP_NUMBER_WIDTH-1:0] head_step;
    logic                           head_dir;
    logic [C_MICROSTEP_WIDTH-1:0]   head_ms;

    // Upstream handshake: a command transfers on a clk where s_valid && s_ready; s_ready
    // does not depend on s_valid, and the command fields must be stable while s_valid is high.
    assign empty      = (wr_ptr_q == rd_ptr_q) && !full_q;
    assign s_ready    = !full_q && !abort_pending_q;
    assign push       = s_valid && s_ready;
    assign abort_rise = abort && !abort_q;
    assign wr_inc     = wr_ptr_q + 1'b1;
    assign rd_inc     = rd_ptr_q + 1'b1;
    assign ptr_diff   = wr_ptr_q - rd_ptr_q;
    assign {head_speed, head_step, head_dir, head_ms} = mem_q[rd_ptr_q];

    assign busy       = (state_q != ST_IDLE) || !empty;
    assign fifo_count = full_q ? {1'b1, {C_FIFO_AW{1'b0}}} : {1'b0, ptr_diff};
    assign m_speed    = m_speed_q;
    assign m_step     = m_step_q;
    assign m_dir      = m_dir_q;
    assign m_ms       = m_ms_q;
    assign m_start    = m_start_q;
    assign m_stop     = m_stop_q;
    assign done       = done_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        abort_pending_d = abort_pending_q;
        m_speed_d       = m_speed_q;
        m_step_d        = m_step_q;
        m_dir_d         = m_dir_q;
        m_ms_d          = m_ms_q;
        m_start_d       = m_start_q;
        m_stop_d        = m_stop_q;
        done_d          = 1'b0;
        err_d           = 1'b0;
        pop             = 1'b0;
        case (state_q)
            ST_IDLE: if (!empty && !m_state && !abort_rise) state_d = ST_LOAD;
            ST_LOAD: begin
                pop = 1'b1;
                if (abort_rise) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end else if (head_step == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    m_speed_d = head_speed;
                    m_step_d  = head_step;
                    m_dir_d   = head_dir;
                    m_ms_d    = head_ms;
                    state_d   = ST_START;
                    cnt_d     = '0;
                end
            end
            // The first START clk only lets the freshly loaded m_* data settle.
            ST_START: begin
                if (abort_rise) begin
                    m_start_d = 1'b0;
                    state_d   = ST_STOP;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_W'(C_PULSE_CYCLES)) begin
                    m_start_d = 1'b0;
                    state_d   = ST_WAIT_ACK;
                    cnt_d     = '0;
                end else begin
                    m_start_d = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                if (abort_rise) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end else if (m_state) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(C_ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (abort_rise) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end else if (!m_state) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_W'(C_PULSE_CYCLES)) begin
                    m_stop_d = 1'b0;
                    state_d  = ST_WAIT_IDLE;
                end else begin
                    m_stop_d = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (!m_state) begin
                    state_d         = ST_IDLE;
                    abort_pending_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // An abort seen in IDLE only flushes; it never blocks new commands.
        if (abort_rise && (state_q inside {ST_LOAD, ST_START, ST_WAIT_ACK, ST_WAIT_DONE}))
            abort_pending_d = 1'b1;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        if (abort_rise) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            full_d   = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_inc;
            if (pop)  rd_ptr_d = rd_inc;
            if (push && !pop)      full_d = (wr_inc == rd_ptr_q);
            else if (pop && !push) full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            full_q          <= 1'b0;
            abort_q         <= 1'b0;
            abort_pending_q <= 1'b0;
            m_speed_q       <= '0;
            m_step_q        <= '0;
            m_dir_q         <= 1'b0;
            m_ms_q          <= '0;
            m_start_q       <= 1'b0;
            m_stop_q        <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            full_q          <= full_d;
            abort_q         <= abort;
            abort_pending_q <= abort_pending_d;
            m_speed_q       <= m_speed_d;
            m_step_q        <= m_step_d;
            m_dir_q         <= m_dir_d;
            m_ms_q          <= m_ms_d;
            m_start_q       <= m_start_d;
            m_stop_q        <= m_stop_d;
            done_q          <= done_d;
            err_q           <= err_d;
        end
    end

    // Storage needs no reset: contents are only read while the pointers say non-empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {s_speed, s_step, s_dir, s_ms};
    end
endmodule

// File: tb/tb_step_motor_cmd_seq.sv
`timescale 1ns/1ps
// Bench for step_motor_cmd_seq: directed scenarios plus randomized commands, a queue of
// expected commands, and a small behavioural motor driving m_state.
module tb_step_motor_cmd_seq;
    localparam int SPD = 16, STP = 16, MS = 3, AW = 3, PULSE = 4, TIMEOUT = 1024;
    localparam int CMD_W = SPD + STP + 1 + MS;

    logic           clk = 1'b0, resetn = 1'b0, s_valid = 1'b0, s_dir = 1'b0, abort = 1'b0;
    logic           m_state = 1'b0;
    logic [SPD-1:0] s_speed = '0;
    logic [STP-1:0] s_step = '0;
    logic [MS-1:0]  s_ms = '0;
    logic           s_ready, m_dir, m_start, m_stop, busy, done, err;
    logic [SPD-1:0] m_speed;
    logic [STP-1:0] m_step;
    logic [MS-1:0]  m_ms;
    logic [AW:0]    fifo_count;
    logic [2:0]     dbg_state;

    step_motor_cmd_seq #(
        .C_STEP_NUMBER_WIDTH(STP), .C_SPEED_DATA_WIDTH(SPD), .C_MICROSTEP_WIDTH(MS),
        .C_FIFO_AW(AW), .C_PULSE_CYCLES(PULSE), .C_ACK_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready),
        .s_speed(s_speed), .s_step(s_step), .s_dir(s_dir), .s_ms(s_ms), .abort(abort),
        .m_speed(m_speed), .m_step(m_step), .m_dir(m_dir), .m_ms(m_ms),
        .m_start(m_start), .m_stop(m_stop), .m_state(m_state), .busy(busy),
        .fifo_count(fifo_count), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int               n_checks = 0, n_errors = 0;
    logic [CMD_W-1:0] exp_q[$];
    int               start_cnt = 0, done_cnt = 0, err_cnt = 0, stop_cnt = 0;
    int               cyc = 0, start_len = 0, stop_len = 0, fall_cyc = 0, timeout_delay = 0;
    int               run_cnt = 0, motor_run_len = 20;
    bit               expect_timeout = 0, motor_dead = 0, motor_hold = 0, in_flight = 0;
    logic             start_prev = 0, stop_prev = 0, done_prev = 0;
    logic [CMD_W-1:0] prev_data = '0, cur_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- motor model + event monitor ----------------
    always @(posedge clk) begin
        #3;
        cyc++;
        if (!resetn) begin
            run_cnt = 0; m_state = 1'b0; start_len = 0; stop_len = 0; in_flight = 0;
            start_prev = 1'b0; stop_prev = 1'b0; done_prev = 1'b0;
        end else begin
            cur_data = {m_speed, m_step, m_dir, m_ms};
            if (run_cnt > 0) run_cnt--;
            if (m_start && !start_prev) begin
                start_cnt++;
                in_flight = 1;
                check("start_data_setup", prev_data, cur_data);
                check("start_has_cmd", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("start_cmd", cur_data, exp_q.pop_front());
                if (!motor_dead) run_cnt = motor_run_len;
            end
            if (m_start) start_len++;
            else if (start_prev) begin
                check("start_len", start_len, PULSE);
                start_len = 0;
                fall_cyc = cyc;
            end
            if (m_stop && !stop_prev) begin
                stop_cnt++;
                in_flight = 0;
                if (run_cnt > 0) run_cnt = 6;
            end
            if (m_stop) stop_len++;
            else if (stop_prev) begin
                check("stop_len", stop_len, PULSE);
                stop_len = 0;
            end
            if (done) begin
                done_cnt++;
                check("done_single", done_prev, 0);
                check("done_after_start", in_flight, 1);
                check("done_motor_idle", m_state, 0);
                in_flight = 0;
            end
            if (err) begin
                err_cnt++;
                check("err_not_with_done", done, 0);
                if (expect_timeout) begin
                    timeout_delay = cyc - fall_cyc;
                    expect_timeout = 0;
                    in_flight = 0;
                end else begin
                    check("err_has_cmd", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("err_zero_step", exp_q.pop_front()[STP+MS:MS+1], 0);
                end
            end
            m_state = motor_hold || (run_cnt > 0);
            start_prev = m_start;
            stop_prev  = m_stop;
            done_prev  = done;
            prev_data  = cur_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_cmd(input logic [SPD-1:0] spd, input logic [STP-1:0] stp,
                            input logic d, input logic [MS-1:0] ms, output bit accepted);
        s_valid = 1'b1; s_speed = spd; s_step = stp; s_dir = d; s_ms = ms;
        accepted = s_ready;
        if (accepted) exp_q.push_back({spd, stp, d, ms});
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy || m_state || m_start || m_stop) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < budget, 1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        bit acc;
        int n, tries, base_done, base_err, base_stop, base_start, n_zero, n_nz;
        logic [STP-1:0] stp;

        repeat (5) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_m_start", m_start, 0);
        check("rst_m_stop", m_stop, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_m_data", {m_speed, m_step, m_dir, m_ms}, 0);

        // single command
        motor_run_len = 50;
        push_cmd(16'd100, 16'd5, 1'b0, 3'd2, acc);
        check("t1_accepted", acc, 1);
        wait_idle("t1_idle", 300);
        check("t1_done_count", done_cnt, 1);
        check("t1_start_count", start_cnt, 1);
        check("t1_m_data", {m_speed, m_step, m_dir, m_ms}, {16'd100, 16'd5, 1'b0, 3'd2});
        check("t1_busy", busy, 0);
        check("t1_no_err", err_cnt, 0);

        // fill the FIFO while the motor reports busy
        motor_run_len = 12;
        motor_hold = 1;
        @(negedge clk);
        base_done = done_cnt;
        for (int i = 0; i < 8; i++) begin
            push_cmd(16'($urandom), 16'($urandom_range(1, 65535)), 1'($urandom_range(0, 1)),
                     3'($urandom_range(0, 7)), acc);
            check("t2_accepted", acc, 1);
        end
        check("t2_count_full", fifo_count, 8);
        check("t2_s_ready_full", s_ready, 0);
        push_cmd(16'd7, 16'd7, 1'b1, 3'd7, acc);
        check("t2_reject_when_full", acc, 0);
        check("t2_count_still_full", fifo_count, 8);
        motor_hold = 0;
        wait_idle("t2_idle", 2000);
        check("t2_done_count", done_cnt - base_done, 8);
        check("t2_count_empty", fifo_count, 0);
        check("t2_model_empty", exp_q.size(), 0);

        // zero-step command is dropped with err
        base_done = done_cnt; base_err = err_cnt;
        push_cmd(16'd200, 16'd0, 1'b1, 3'd1, acc);
        push_cmd(16'd300, 16'd3, 1'b0, 3'd4, acc);
        wait_idle("t3_idle", 300);
        check("t3_err_count", err_cnt - base_err, 1);
        check("t3_done_count", done_cnt - base_done, 1);
        check("t3_m_step", m_step, 3);

        // abort during WAIT_DONE with three queued
        motor_run_len = 200;
        base_done = done_cnt; base_stop = stop_cnt; base_start = start_cnt;
        push_cmd(16'd500, 16'd1000, 1'b1, 3'd7, acc);
        n = 0;
        while (start_cnt == base_start && n < 50) begin @(negedge clk); n++; end
        check("t4_started", start_cnt - base_start, 1);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++)
            push_cmd(16'($urandom), 16'($urandom_range(1, 65535)), 1'b0, 3'd3, acc);
        check("t4_count3", fifo_count, 3);
        abort = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("t4_flushed", fifo_count, 0);
        check("t4_s_ready_pending", s_ready, 0);
        wait_idle("t4_idle", 200);
        check("t4_stop_count", stop_cnt - base_stop, 1);
        check("t4_no_done", done_cnt - base_done, 0);
        check("t4_s_ready_back", s_ready, 1);
        abort = 1'b0;
        @(negedge clk);

        // ack timeout, then the next command goes through
        motor_run_len = 15;
        motor_dead = 1; expect_timeout = 1;
        base_done = done_cnt; base_err = err_cnt;
        push_cmd(16'd40, 16'd50, 1'b0, 3'd0, acc);
        push_cmd(16'd41, 16'd60, 1'b1, 3'd5, acc);
        n = 0;
        while (err_cnt == base_err && n < 1300) begin @(negedge clk); n++; end
        motor_dead = 0;
        check("t5_err_seen", err_cnt - base_err, 1);
        check("t5_ack_timeout_cycles", timeout_delay, TIMEOUT);
        check("t5_m_start_low", m_start, 0);
        wait_idle("t5_idle", 300);
        check("t5_next_done", done_cnt - base_done, 1);
        check("t5_err_once", err_cnt - base_err, 1);

        // reset in the middle of START
        motor_run_len = 100;
        push_cmd(16'd60, 16'd70, 1'b1, 3'd6, acc);
        push_cmd(16'd61, 16'd71, 1'b0, 3'd1, acc);
        n = 0;
        while (m_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("t6_start_seen", m_start, 1);
        resetn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t6_m_start_low", m_start, 0);
        check("t6_fifo_count", fifo_count, 0);
        check("t6_busy", busy, 0);
        check("t6_m_data", {m_speed, m_step, m_dir, m_ms}, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("t6_s_ready", s_ready, 1);

        // randomized commands, some with zero steps
        base_done = done_cnt; base_err = err_cnt; n_zero = 0; n_nz = 0;
        for (int i = 0; i < 16; i++) begin
            stp = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            motor_run_len = int'($urandom_range(10, 30));
            acc = 0; tries = 0;
            while (!acc && tries < 500) begin
                push_cmd(16'($urandom), stp, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), acc);
                tries++;
            end
            check("rand_accepted", acc, 1);
            if (stp == 0) n_zero++; else n_nz++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle("rand_idle", 5000);
        check("rand_done_count", done_cnt - base_done, n_nz);
        check("rand_err_count", err_cnt - base_err, n_zero);
        check("rand_model_empty", exp_q.size(), 0);
        check("rand_fifo_empty", fifo_count, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
